i2s_transmitter: RTL and testbench

- Playback-side I2S master that serialises 16-bit stereo samples to an external DAC/amplifier. It is the transmit counterpart of the microphone I2S capture path.
- Runs in the 98.304 MHz audio domain (clk_m). It takes samples from a valid/ready source (playback mux or synthesiser) through a one-entry holding register, and generates SCK, WS and SD.
- Default rates: SCK 3.072 MHz, frame 48 kHz, 64 SCK per frame.

---
 rtl/audio_pkg.sv | 9 +
 rtl/i2s_clk_div.sv | 23 ++
 rtl/i2s_transmitter.sv | 69 ++++++
 tb/tb_i2s_transmitter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-domain constants and sample types
package audio_pkg;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_SLOTS_PER_FRAME = 64;
  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: SCK generator with a strobe marking each high->low edge
module i2s_clk_div #(
  parameter int SCK_HALF = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sck,
  output logic fall_strobe
);
  localparam int CW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(SCK_HALF - 1);
  assign fall_strobe = wrap && sck;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      sck <= sck ^ wrap;
    end
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master serialising stereo samples from a one-entry holding register
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int SCK_HALF   = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_left_in,
  input  logic [DATA_WIDTH-1:0] sample_right_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  output logic                  i2s_sck_out,
  output logic                  i2s_ws_out,
  output logic                  i2s_sd_out,
  output logic                  underrun_out
);
  localparam int KW = $clog2(I2S_SLOTS_PER_FRAME);
  localparam int PW = $clog2(I2S_SLOT_BITS);
  logic                  fall, full, load, accept, sd_nx;
  logic [KW-1:0]         k, k_nx;
  logic [PW-1:0]         pos;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, sh_l, sh_r, word, word_sh;
  i2s_clk_div #(.SCK_HALF(SCK_HALF)) u_div (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sck         (i2s_sck_out),
    .fall_strobe (fall)
  );
  // slot position 0 of each half-frame is the I2S one-bit delay, so data occupies 1..DATA_WIDTH
  always_comb begin
    k_nx    = k + 1'b1;
    pos     = k_nx[PW-1:0];
    load    = fall && k_nx == '0;
    accept  = sample_valid_in && !full;
    word    = k_nx[KW-1] ? sh_r : sh_l;
    word_sh = word << (pos - 1'b1);
    sd_nx   = pos != '0 && 32'(pos) <= DATA_WIDTH && word_sh[DATA_WIDTH-1];
  end
  assign sample_ready_out = !full;
  assign underrun_out = load && !full;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      k          <= '1;
      i2s_ws_out <= 1'b1;
      i2s_sd_out <= 1'b0;
      full       <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
    end else begin
      if (fall) begin
        k          <= k_nx;
        i2s_ws_out <= k_nx[KW-1];
        i2s_sd_out <= sd_nx;
      end
      if (load) begin
        sh_l <= full ? hold_l : '0;
        sh_r <= full ? hold_r : '0;
      end
      if (accept) begin
        hold_l <= sample_left_in;
        hold_r <= sample_right_in;
      end
      full <= accept | (full & !load);
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: scoreboard bench decoding I2S frames against queued expected pairs
module tb_i2s_transmitter;
  import audio_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] sl = '0, sr = '0;
  logic valid = 1'b0;
  logic ready, sck, ws, sd, und;
  int cyc;
  int n_cmp = 0, n_err = 0;
  stereo_sample_t exp_q[$];
  int exp_u[$];

  i2s_transmitter #(.SCK_HALF(16), .DATA_WIDTH(16)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_left_in   (sl),
    .sample_right_in  (sr),
    .sample_valid_in  (valid),
    .sample_ready_out (ready),
    .i2s_sck_out      (sck),
    .i2s_ws_out       (ws),
    .i2s_sd_out       (sd),
    .underrun_out     (und)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input int u);
    stereo_sample_t e;
    e.left = l;
    e.right = r;
    exp_q.push_back(e);
    exp_u.push_back(u);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  // monitor: decodes SD/WS on SCK rising edges, one frame per 64 rises
  initial begin
    int slot = -1, ucnt = 0, last_rise = -1, last_f0 = -1, fu = 0;
    logic prev_sck = 1'b0, prev_ws = 1'b1;
    logic [63:0] bits = '0, wsb = '0;
    stereo_sample_t e;
    int eu;
    forever begin
      @(negedge clk);
      if (rst) begin
        slot = -1; ucnt = 0; last_rise = -1; last_f0 = -1;
        prev_sck = 1'b0; prev_ws = 1'b1;
      end else begin
        if (und) ucnt++;
        if (sck && !prev_sck) begin
          if (last_rise >= 0) chk("sck_period", 64'(cyc - last_rise), 64'd32);
          last_rise = cyc;
          if (!ws && prev_ws) begin
            if (last_f0 >= 0) chk("frame_period", 64'(cyc - last_f0), 64'd2048);
            last_f0 = cyc; slot = 0; fu = ucnt; ucnt = 0;
          end
          if (slot >= 0) begin
            bits = {bits[62:0], sd};
            wsb = {wsb[62:0], ws};
            if (slot == 63) begin
              slot = -1;
              if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
              else begin
                e = exp_q.pop_front();
                eu = exp_u.pop_front();
                chk("frame_sd", bits, {1'b0, e.left, 15'b0, 1'b0, e.right, 15'b0});
                chk("frame_ws", wsb, 64'h00000000FFFFFFFF);
                chk("frame_underrun", 64'(fu), 64'(eu));
              end
            end else slot++;
          end
          prev_ws = ws;
        end
        prev_sck = sck;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({sck, ws, sd, ready, und}), 64'b01010);
    rst = 1'b0;
    wait_cyc(50);
    chk("pre_async_state", 64'({sck, ws}), 64'b10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", 64'({sck, ws, sd, ready, und}), 64'b01010);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(16'h0, 16'h0, 1);
    wait_cyc(15); chk("sck_before_rise", 64'(sck), 64'd0);
    wait_cyc(16); chk("sck_first_rise", 64'(sck), 64'd1);
    wait_cyc(31); chk("underrun_load_cycle", 64'({und, sck}), 64'b11);
    wait_cyc(32); chk("first_fall", 64'({sck, ws, und}), 64'b000);
    wait_cyc(100);
    sl = 16'hA5C3; sr = 16'h0F0F; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; sl = 16'hDEAD; sr = 16'hBEEF;
    chk("ready_after_accept", 64'(ready), 64'd0);
    push(16'hA5C3, 16'h0F0F, 0);
    wait_cyc(2079); chk("ready_before_load", 64'(ready), 64'd0);
    wait_cyc(2080); chk("ready_after_load", 64'(ready), 64'd1);
    wait_cyc(2200);
    for (int i = 1; i <= 4; i++) begin
      sl = 16'(i); sr = 16'(0 - i); valid = 1'b1;
      wait_ready();
      @(negedge clk);
      if (i > 1) chk("stream_accept_cycle", 64'(cyc), 64'(32 + 2048 * i + 1));
      push(16'(i), 16'(0 - i), 0);
    end
    valid = 1'b0;
    push(16'h0, 16'h0, 1);
    wait_cyc(14367);
    chk("race_ready", 64'({ready, und}), 64'b11);
    sl = 16'h1234; sr = 16'h8001; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("race_held", 64'(ready), 64'd0);
    push(16'h0, 16'h0, 1);
    push(16'h1234, 16'h8001, 0);
    push(16'h0, 16'h0, 1);
    wait_cyc(18600);
    sl = 16'h7777; sr = 16'h3333; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_cyc(19760);
    chk("pending_before_reset", 64'(exp_q.size()), 64'd1);
    #2 rst = 1'b1;
    #1 chk("midframe_reset", 64'({sck, ws, sd, ready, und}), 64'b01010);
    exp_q.delete();
    exp_u.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(16'h0, 16'h0, 1);
    push(16'h0, 16'h0, 1);
    wait_cyc(4130);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
